// File: rtl/cpu_useq_if.sv
// cpu_useq_if: sequencer bus bundling ROM access, datapath flags/handshake and control outputs.
interface cpu_useq_if #(
   parameter int OPC_W  = 4,
   parameter int CTRL_W = 15,
   parameter int FLAG_W = 2,
   parameter int STEP_W = 3
);
   localparam int CSEL_W = (FLAG_W > 2) ? $clog2(FLAG_W) : 1;
   localparam int UW_W   = CTRL_W + 5 + CSEL_W;
   logic [OPC_W-1:0]        reg_ir;
   logic [FLAG_W-1:0]       flag_lines;
   logic                    mem_ready;
   logic                    run;
   logic                    step_req;
   logic [OPC_W+STEP_W-1:0] uaddr;
   logic [UW_W-1:0]         uword;
   logic [CTRL_W-1:0]       control_lines;
   logic                    instr_done;
   logic                    halted;
   logic                    ucode_err;
   modport master (
      input  reg_ir, flag_lines, mem_ready, run, step_req, uword,
      output uaddr, control_lines, instr_done, halted, ucode_err
   );
   modport slave (
      output reg_ir, flag_lines, mem_ready, run, step_req, uword,
      input  uaddr, control_lines, instr_done, halted, ucode_err
   );
endinterface

// File: rtl/cpu_useq.sv
// cpu_useq: microcode sequencer; fixed two-step fetch, then execute steps read from an async ROM at {opcode, step}.
module cpu_useq #(
   parameter int OPC_W  = 4,
   parameter int CTRL_W = 15,
   parameter int FLAG_W = 2,
   parameter int STEP_W = 3,
   parameter logic [CTRL_W-1:0] FETCH0_CW = '0,
   parameter logic [CTRL_W-1:0] FETCH1_CW = '0
) (
   input logic clk,
   input logic rst,
   cpu_useq_if.master bus
);
   localparam int CSEL_W = (FLAG_W > 2) ? $clog2(FLAG_W) : 1;
   localparam int FE_W   = 1 << CSEL_W;
   typedef enum logic [2:0] {FETCH0, FETCH1, EXEC, PAUSE, HALT} state_t;
   state_t             state, nstate;
   logic [STEP_W-1:0]  step, nstep;
   logic               ucode_err, err_set;
   logic [CTRL_W-1:0]  cl;
   logic               done, fin;
   logic [CTRL_W-1:0]  u_ctrl;
   logic               u_end, u_hlt, u_wait, u_cen, u_pol;
   logic [CSEL_W-1:0]  u_sel;
   logic [FE_W-1:0]    flag_ext;
   logic               cond_ok;
   assign u_ctrl   = bus.uword[CTRL_W-1:0];
   assign u_end    = bus.uword[CTRL_W];
   assign u_hlt    = bus.uword[CTRL_W+1];
   assign u_wait   = bus.uword[CTRL_W+2];
   assign u_cen    = bus.uword[CTRL_W+3];
   assign u_pol    = bus.uword[CTRL_W+4];
   assign u_sel    = bus.uword[CTRL_W+5 +: CSEL_W];
   // Zero-extending the flags makes out-of-range selects read as 0.
   assign flag_ext = FE_W'(bus.flag_lines);
   assign cond_ok  = !u_cen || (flag_ext[u_sel] == u_pol);
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH0;
         step      <= '0;
         ucode_err <= 1'b0;
      end else begin
         state     <= nstate;
         step      <= nstep;
         ucode_err <= ucode_err | err_set;
      end
   end
   always_comb begin
      nstate  = state;
      nstep   = step;
      cl      = '0;
      done    = 1'b0;
      fin     = 1'b0;
      err_set = 1'b0;
      case (state)
         FETCH0: begin
            cl     = FETCH0_CW;
            nstate = FETCH1;
         end
         FETCH1: if (bus.mem_ready) begin
            cl     = FETCH1_CW;
            nstate = EXEC;
            nstep  = '0;
         end
         EXEC: if (!(u_wait && !bus.mem_ready)) begin
            if (!cond_ok) fin = 1'b1;
            else begin
               cl = u_ctrl;
               if (u_hlt) begin
                  nstate = HALT;
                  nstep  = '0;
                  done   = 1'b1;
               end else if (u_end) fin = 1'b1;
               else if (&step) begin
                  err_set = 1'b1;
                  fin     = 1'b1;
               end else nstep = step + 1'b1;
            end
         end
         PAUSE: nstate = (bus.step_req || bus.run) ? FETCH0 : PAUSE;
         default: ;
      endcase
      if (fin) begin
         done   = 1'b1;
         nstep  = '0;
         nstate = bus.run ? FETCH0 : PAUSE;
      end
   end
   assign bus.uaddr         = {bus.reg_ir, step};
   assign bus.control_lines = rst ? '0 : cl;
   assign bus.instr_done    = !rst && done;
   assign bus.halted        = !rst && state == HALT;
   assign bus.ucode_err     = ucode_err;
endmodule

// File: doc/cpu_useq.md
Name: cpu_useq

Overview:
- Parametrised microcode sequencer; successor to the fixed 4-state hard-decoded control unit.
- Drives the datapath control word through a fixed 2-step fetch (parameter words), then a variable-length execute phase read from an external async microcode ROM addressed by {opcode, step}.
- Adds conditional skip, memory-ready stalls, halt, single-step mode, instruction-done strobe and microcode-overrun detection.

Parameters:
- OPC_W, 4: opcode width.
- CTRL_W, 15: control word width.
- FLAG_W, 2: number of ALU flags.
- STEP_W, 3: execute-step counter width; max exec steps = 2**STEP_W.
- FETCH0_CW, 15'h0 (team sets EP|LM): control word for fetch step 0.
- FETCH1_CW, 15'h0 (team sets C|LI|EM): control word for fetch step 1 (memory read).
- Derived: CSEL_W = max(1, clog2(FLAG_W)); UW_W = CTRL_W+5+CSEL_W.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset.
- reg_ir  in  OPC_W  current opcode; valid from the first EXEC cycle on.
- flag_lines  in  FLAG_W  ALU flags, sampled combinationally.
- mem_ready  in  1  memory completes the access this cycle.
- run  in  1  1 = free-run, 0 = single-step.
- step_req  in  1  single-cycle pulse; releases one instruction from PAUSE.
- uaddr  out  OPC_W+STEP_W  {reg_ir, step} to the microcode ROM.
- uword  in  UW_W  microword.
  - [CTRL_W-1:0] control bits
  - [CTRL_W] END
  - [+1] HLT
  - [+2] WAIT (memory access)
  - [+3] COND_EN
  - [+4] COND_POL
  - [+5 +: CSEL_W] COND_SEL
- control_lines  out  CTRL_W  control word for the current cycle (combinational).
- instr_done  out  1  one-cycle strobe in the final cycle of each instruction.
- halted  out  1  high in HALT state.
- ucode_err  out  1  sticky microcode-overrun error.

Behaviour:
- Interface:
  - One clock; reset is synchronous and active-high.
  - rst sampled at posedge; while rst is high: state=FETCH0, step=0, ucode_err=0, and control_lines=0, instr_done=0, halted=0 combinationally.
  - Reset asserted mid-instruction or mid-stall abandons the instruction; the first fetch begins in the cycle after rst falls.
- States: FETCH0, FETCH1, EXEC, PAUSE, HALT.
- FETCH0:
  - control_lines = FETCH0_CW.
  - Next state FETCH1.
- FETCH1:
  - Read access; control_lines = FETCH1_CW if mem_ready, else 0 (stall, no repeated PC increment).
  - Advances to EXEC with step=0 only when mem_ready=1.
- EXEC, per cycle:
  - cond_ok = !COND_EN | (flag_lines[COND_SEL] == COND_POL).
  - COND_SEL >= FLAG_W reads as 0.
  - Stall: WAIT=1 and mem_ready=0 → control_lines=0, step holds.
  - Else if !cond_ok: control_lines=0 and the instruction ends (skip). This is how conditional jumps are encoded.
  - Else: control_lines = uword control bits.
    - HLT=1 → HALT, with instr_done=1.
    - END=1 → instruction ends.
    - Otherwise step+1.
  - Overrun: step == 2**STEP_W-1 without END/HLT/skip → ucode_err set (sticky until rst) and the instruction is forced to end.
- Instruction end:
  - instr_done=1 that cycle; step←0.
  - Next state FETCH0 if run=1, else PAUSE.
- PAUSE:
  - control_lines=0.
  - step_req=1 or run=1 → FETCH0 next cycle.
- HALT:
  - control_lines=0; halted=1.
  - Exits only via rst; step_req and run are ignored.
- Simultaneous events:
  - HLT wins over END.
  - Skip (cond false) wins over HLT/END, and never halts.
  - WAIT stall is evaluated before cond/END.
- uaddr = {reg_ir, step} in all states; the ROM is content-only.
- Latency: an instruction with N exec steps and no stalls takes 2+N cycles, back-to-back in run mode.

Test Plan:
- Reset then run=1, mem_ready=1, opcode 4'h1 with 1-step microword (LA|EI, END) → control_lines sequence FETCH0_CW, FETCH1_CW, LA|EI; instr_done pulses in cycle 3; FETCH0 again in cycle 4.
- mem_ready held 0 for 3 cycles during FETCH1 → control_lines=0 for 3 cycles, then FETCH1_CW once; no extra cycles elsewhere.
- Conditional jump, COND_EN=1, COND_SEL=0, COND_POL=1, word EI|LP|END:
  - flag_lines=2'b01 → EI|LP asserted, instr_done.
  - flag_lines=2'b00 → control_lines=0, instr_done, next FETCH0.
- run=0: after first instruction → PAUSE with control_lines=0 for 5 cycles; step_req pulse → FETCH0 next cycle; exactly one instruction completes.
- HLT microword → halted=1; control_lines=0 for 10 cycles despite step_req/run; rst pulse → FETCH0, halted=0.
- STEP_W=2 ROM with no END in 4 steps → ucode_err=1 after step 3, forced instr_done, next fetch proceeds; ucode_err clears only on rst.
